// File: rtl/lcd1602_if.sv
// LCD1602 pin bus between the APB-side controller and the panel model.
// The controller drives en/rs/rw/data_i, and the panel drives data_o/data_oe.
interface lcd1602_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_i;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;

  modport master (
    output lcd_en, lcd_rs, lcd_rw, lcd_data_i,
    input  lcd_data_o, lcd_data_oe
  );

  modport slave (
    input  lcd_en, lcd_rs, lcd_rw, lcd_data_i,
    output lcd_data_o, lcd_data_oe
  );
endinterface

// File: rtl/lcd1602_resp.sv
// HD44780-compatible LCD1602 panel model holding 80 bytes of DDRAM.
// It also models the address counter, the display state and the busy flag.
module lcd1602_resp #(
  parameter int BUSY_CYC  = 37,
  parameter int BUSY_LONG = 152
) (
  input  logic        pclk,
  input  logic        rst,
  lcd1602_if.slave    bus,
  output logic        busy,
  output logic [6:0]  ac,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic [5:0]  shift_ofs,
  output logic        err,
  input  logic [6:0]  dbg_addr,
  output logic [7:0]  dbg_data
);
  localparam int BW = $clog2(BUSY_LONG + 1);
  localparam logic [BW-1:0] BCYC  = BW'(BUSY_CYC);
  localparam logic [BW-1:0] BLONG = BW'(BUSY_LONG);

  logic [7:0]    mem [80];
  logic          en_q, cap_rs, cap_rw;
  logic [7:0]    cap_d;
  logic          id, sh;
  logic [BW-1:0] busy_cnt;
  logic          fill_on;
  logic [6:0]    fill_idx;
  logic          commit, wr_ok, mem_we, rd_oe;
  logic [6:0]    mem_wa;
  logic [7:0]    mem_wd, rd_ram;

  function automatic logic a_ok(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  // Line 2 (0x40..0x67) packs directly after line 1 in storage.
  function automatic logic [6:0] a_idx(input logic [6:0] a);
    return a[6] ? a - 7'd24 : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a,
                                         input logic up);
    if (up)
      return (a == 7'h27) ? 7'h40 :
             (a == 7'h67) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h67 :
           (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  function automatic logic [5:0] ofs_step(input logic [5:0] o,
                                          input logic up);
    if (up)
      return (o == 6'd39) ? 6'd0 : o + 6'd1;
    return (o == 6'd0) ? 6'd39 : o - 6'd1;
  endfunction

  assign busy   = busy_cnt != '0;
  assign commit = en_q & ~bus.lcd_en;
  assign wr_ok  = commit & cap_rs & ~cap_rw & ~busy & a_ok(ac);
  assign mem_we = ~rst & (fill_on | wr_ok);
  assign mem_wa = fill_on ? fill_idx : a_idx(ac);
  assign mem_wd = fill_on ? 8'h20 : cap_d;

  assign rd_oe  = bus.lcd_en & bus.lcd_rw;
  assign rd_ram = a_ok(ac) ? mem[a_idx(ac)] : 8'h20;
  assign bus.lcd_data_oe = rd_oe;
  assign bus.lcd_data_o  = !rd_oe     ? 8'h00 :
                           bus.lcd_rs ? rd_ram : {busy, ac};

  always_ff @(posedge pclk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      en_q      <= 1'b0;
      cap_rs    <= 1'b0;
      cap_rw    <= 1'b0;
      cap_d     <= 8'h00;
      ac        <= 7'h00;
      id        <= 1'b1;
      sh        <= 1'b0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      shift_ofs <= 6'd0;
      err       <= 1'b0;
      dbg_data  <= 8'h00;
      busy_cnt  <= BLONG;
      fill_on   <= 1'b1;
      fill_idx  <= 7'd0;
    end else begin
      en_q <= bus.lcd_en;
      if (bus.lcd_en) begin
        cap_rs <= bus.lcd_rs;
        cap_rw <= bus.lcd_rw;
        cap_d  <= bus.lcd_data_i;
      end
      err <= 1'b0;
      dbg_data <= a_ok(dbg_addr) ? mem[a_idx(dbg_addr)] : 8'h00;
      if (busy)
        busy_cnt <= busy_cnt - 1'b1;
      if (fill_on) begin
        fill_idx <= fill_idx + 7'd1;
        if (fill_idx == 7'd79)
          fill_on <= 1'b0;
      end
      if (commit) begin
        if (cap_rw) begin
          if (cap_rs)
            ac <= ac_step(ac, id);
        end else if (busy) begin
          err <= 1'b1;
        end else if (cap_rs) begin
          if (a_ok(ac)) begin
            ac       <= ac_step(ac, id);
            busy_cnt <= BCYC;
            if (sh)
              shift_ofs <= ofs_step(shift_ofs, id);
          end else begin
            err <= 1'b1;
          end
        end else begin
          priority case (1'b1)
            cap_d[7]: begin
              if (a_ok(cap_d[6:0])) begin
                ac       <= cap_d[6:0];
                busy_cnt <= BCYC;
              end else begin
                err <= 1'b1;
              end
            end
            cap_d[6]: err <= 1'b1;
            cap_d[5]: begin
              busy_cnt <= BCYC;
              err      <= ~cap_d[4];
            end
            cap_d[4]: begin
              busy_cnt <= BCYC;
              if (cap_d[3])
                shift_ofs <= ofs_step(shift_ofs, cap_d[2]);
              else
                ac <= ac_step(ac, cap_d[2]);
            end
            cap_d[3]: begin
              disp_on   <= cap_d[2];
              cursor_on <= cap_d[1];
              blink_on  <= cap_d[0];
              busy_cnt  <= BCYC;
            end
            cap_d[2]: begin
              id       <= cap_d[1];
              sh       <= cap_d[0];
              busy_cnt <= BCYC;
            end
            cap_d[1]: begin
              ac        <= 7'h00;
              shift_ofs <= 6'd0;
              busy_cnt  <= BLONG;
            end
            cap_d[0]: begin
              ac        <= 7'h00;
              id        <= 1'b1;
              shift_ofs <= 6'd0;
              busy_cnt  <= BLONG;
              fill_on   <= 1'b1;
              fill_idx  <= 7'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd1602_resp.sv
// Directed bench for lcd1602_resp that drives the pin bus like the controller.
// It checks the register state, the read data and the DDRAM contents on the debug port.
module tb_lcd1602_resp;
  logic       pclk = 1'b0;
  logic       rst;
  logic       busy, disp_on, cursor_on, blink_on, err;
  logic [6:0] ac, dbg_addr;
  logic [5:0] shift_ofs;
  logic [7:0] dbg_data;
  int checks = 0;
  int failures = 0;

  lcd1602_if bus();

  lcd1602_resp dut (
    .pclk      (pclk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .ac        (ac),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .shift_ofs (shift_ofs),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic       e_err;
    logic       e_busy;
    logic [6:0] e_ac;
    logic [5:0] e_sh;
    logic [2:0] e_dcb;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic xact(input logic rs, input logic rw, input logic [7:0] d,
                      output logic [7:0] rd, output logic oe);
    bus.lcd_en = 1'b1;
    bus.lcd_rs = rs;
    bus.lcd_rw = rw;
    bus.lcd_data_i = d;
    @(negedge pclk);
    rd = bus.lcd_data_o;
    oe = bus.lcd_data_oe;
    tick();
    bus.lcd_en = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy)
      chk("idle_timeout", 1, 0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic dbg_rd(input logic [6:0] a, output logic [7:0] v);
    dbg_addr = a;
    tick();
    v = dbg_data;
  endtask

  initial begin
    logic [7:0] rd, v;
    logic oe;
    int n;

    bus.lcd_en = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data_i = 8'h00;
    dbg_addr = 7'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    chk("rst_busy", busy, 1);
    chk("rst_ac", ac, 0);
    chk("rst_shift", shift_ofs, 0);
    chk("rst_dcb", {disp_on, cursor_on, blink_on}, 0);
    chk("rst_err", err, 0);
    chk("rst_dbg", dbg_data, 0);
    chk("rst_oe", bus.lcd_data_oe, 0);
    chk("rst_do", bus.lcd_data_o, 0);
    count_busy(n);
    chk("rst_busy_len", n, 152);
    for (int a = 0; a < 128; a++) begin
      if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
        dbg_rd(7'(a), v);
        chk($sformatf("fill_%0h", a), v, 8'h20);
      end
    end

    //              rs rw d      err bsy ac     sh  dcb   rd
    tv[0]  = '{1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 7'h00, 6'd0,  3'b000, 8'h00};
    tv[1]  = '{1'b0, 1'b0, 8'h0C, 1'b0, 1'b1, 7'h00, 6'd0,  3'b100, 8'h00};
    tv[2]  = '{1'b0, 1'b0, 8'hC0, 1'b0, 1'b1, 7'h40, 6'd0,  3'b100, 8'h00};
    tv[3]  = '{1'b1, 1'b0, 8'h48, 1'b0, 1'b1, 7'h41, 6'd0,  3'b100, 8'h00};
    tv[4]  = '{1'b1, 1'b0, 8'h49, 1'b0, 1'b1, 7'h42, 6'd0,  3'b100, 8'h00};
    tv[5]  = '{1'b0, 1'b0, 8'hA7, 1'b0, 1'b1, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[6]  = '{1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 7'h40, 6'd0,  3'b100, 8'h00};
    tv[7]  = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 7'h40, 6'd0,  3'b100, 8'h00};
    tv[8]  = '{1'b1, 1'b0, 8'h42, 1'b0, 1'b1, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[9]  = '{1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[10] = '{1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[11] = '{1'b0, 1'b0, 8'hA8, 1'b1, 1'b0, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[12] = '{1'b0, 1'b0, 8'h30, 1'b0, 1'b1, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[13] = '{1'b0, 1'b0, 8'h18, 1'b0, 1'b1, 7'h27, 6'd39, 3'b100, 8'h00};
    tv[14] = '{1'b0, 1'b0, 8'h1C, 1'b0, 1'b1, 7'h27, 6'd0,  3'b100, 8'h00};
    tv[15] = '{1'b0, 1'b0, 8'h85, 1'b0, 1'b1, 7'h05, 6'd0,  3'b100, 8'h00};
    tv[16] = '{1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 7'h05, 6'd0,  3'b100, 8'h00};
    tv[17] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 7'h06, 6'd1,  3'b100, 8'h00};
    tv[18] = '{1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 7'h06, 6'd1,  3'b100, 8'h00};
    tv[19] = '{1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 7'h06, 6'd1,  3'b111, 8'h00};
    tv[20] = '{1'b0, 1'b0, 8'hE7, 1'b0, 1'b1, 7'h67, 6'd1,  3'b111, 8'h00};
    tv[21] = '{1'b0, 1'b0, 8'h14, 1'b0, 1'b1, 7'h00, 6'd1,  3'b111, 8'h00};
    tv[22] = '{1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 7'h67, 6'd1,  3'b111, 8'h00};
    tv[23] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'h67, 6'd1,  3'b111, 8'h67};
    tv[24] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 7'h00, 6'd1,  3'b111, 8'h20};

    foreach (tv[i]) begin
      wait_idle();
      xact(tv[i].rs, tv[i].rw, tv[i].d, rd, oe);
      chk($sformatf("v%0d_oe", i), oe, tv[i].rw);
      chk($sformatf("v%0d_rd", i), rd, tv[i].e_rd);
      chk($sformatf("v%0d_err", i), err, tv[i].e_err);
      chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d_ac", i), ac, tv[i].e_ac);
      chk($sformatf("v%0d_sh", i), shift_ofs, tv[i].e_sh);
      chk($sformatf("v%0d_dcb", i),
          {disp_on, cursor_on, blink_on}, tv[i].e_dcb);
      tick();
      chk($sformatf("v%0d_err_end", i), err, 0);
    end

    dbg_rd(7'h40, v); chk("ram_40", v, 8'h42);
    dbg_rd(7'h41, v); chk("ram_41", v, 8'h49);
    dbg_rd(7'h27, v); chk("ram_27", v, 8'h41);
    dbg_rd(7'h05, v); chk("ram_05", v, 8'h5A);
    dbg_rd(7'h06, v); chk("ram_06", v, 8'h20);
    dbg_rd(7'h28, v); chk("ram_bad28", v, 8'h00);
    dbg_rd(7'h7F, v); chk("ram_bad7f", v, 8'h00);

    // Home keeps the DDRAM contents but resets ac and shift_ofs.
    wait_idle();
    xact(1'b0, 1'b0, 8'h85, rd, oe);
    wait_idle();
    xact(1'b0, 1'b0, 8'h1C, rd, oe);
    chk("home_pre_sh", shift_ofs, 2);
    wait_idle();
    xact(1'b0, 1'b0, 8'h02, rd, oe);
    chk("home_ac", ac, 0);
    chk("home_sh", shift_ofs, 0);
    count_busy(n);
    chk("home_busy_len", n, 152);
    dbg_rd(7'h05, v); chk("home_ram_05", v, 8'h5A);

    // A data write is busy for 37 cycles, and a write during busy is dropped.
    xact(1'b0, 1'b0, 8'h80, rd, oe);
    wait_idle();
    xact(1'b1, 1'b0, 8'h55, rd, oe);
    count_busy(n);
    chk("wr_busy_len", n, 37);
    chk("wr_ac", ac, 1);
    xact(1'b1, 1'b0, 8'h66, rd, oe);
    repeat (5) tick();
    xact(1'b0, 1'b1, 8'h00, rd, oe);
    chk("stat_busy_rd", rd, 8'h82);
    chk("stat_oe", oe, 1);
    xact(1'b1, 1'b0, 8'h77, rd, oe);
    chk("drop_err", err, 1);
    tick();
    chk("drop_err_end", err, 0);
    chk("drop_ac", ac, 2);
    dbg_rd(7'h00, v); chk("drop_ram_00", v, 8'h55);
    dbg_rd(7'h01, v); chk("drop_ram_01", v, 8'h66);
    dbg_rd(7'h02, v); chk("drop_ram_02", v, 8'h20);

    // Back-to-back strobes: the second is dropped only when busy.
    wait_idle();
    xact(1'b0, 1'b1, 8'h00, rd, oe);
    chk("b2b_stat", rd, 8'h02);
    xact(1'b0, 1'b0, 8'h83, rd, oe);
    chk("b2b_err1", err, 0);
    chk("b2b_ac1", ac, 3);
    xact(1'b0, 1'b0, 8'h84, rd, oe);
    chk("b2b_err2", err, 1);
    chk("b2b_ac2", ac, 3);

    // The debug port returns the old byte when a write lands in the same cycle.
    wait_idle();
    xact(1'b0, 1'b0, 8'h90, rd, oe);
    wait_idle();
    dbg_addr = 7'h10;
    xact(1'b1, 1'b0, 8'h99, rd, oe);
    chk("dbg_old", dbg_data, 8'h20);
    tick();
    chk("dbg_new", dbg_data, 8'h99);

    // Clear fills every byte with spaces and resets ac and shift_ofs.
    wait_idle();
    xact(1'b0, 1'b0, 8'h1C, rd, oe);
    wait_idle();
    xact(1'b0, 1'b0, 8'h01, rd, oe);
    chk("clr_ac", ac, 0);
    chk("clr_sh", shift_ofs, 0);
    count_busy(n);
    chk("clr_busy_len", n, 152);
    dbg_rd(7'h10, v); chk("clr_ram_10", v, 8'h20);
    dbg_rd(7'h00, v); chk("clr_ram_00", v, 8'h20);
    dbg_rd(7'h40, v); chk("clr_ram_40", v, 8'h20);
    dbg_rd(7'h67, v); chk("clr_ram_67", v, 8'h20);

    // A reset in the middle of a busy period reloads the long busy and refills.
    xact(1'b1, 1'b0, 8'h31, rd, oe);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ac", ac, 0);
    count_busy(n);
    chk("rst2_busy_len", n, 152);
    dbg_rd(7'h00, v); chk("rst2_ram_00", v, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
